dmem_arbiter: RTL and testbench



---
 rtl/vp_pkg.sv | 13 +
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vp_pkg.sv
// Shared memory-stage types and widths for dmem, mexecute and dmem_arbiter.
package vp_pkg;

  localparam int DMEM_AW = 15;
  localparam int DMEM_DW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side command, write-beat and read-return bus for dmem_arbiter.
interface dmem_arbiter_if #(
  parameter int NREQ = 2,
  parameter int LENW = 3
) ();

  logic [NREQ-1:0]                          cmd_valid;
  logic [NREQ-1:0]                          cmd_ready;
  logic [NREQ-1:0]                          cmd_write;
  logic [NREQ-1:0][vp_pkg::DMEM_AW-1:0]     cmd_addr;
  logic [NREQ-1:0][LENW-1:0]                cmd_len;
  logic [NREQ-1:0]                          wvalid;
  logic [NREQ-1:0]                          wready;
  logic [NREQ-1:0][vp_pkg::DMEM_DW-1:0]     wdata;
  logic [NREQ-1:0]                          rvalid;
  logic                                     rlast;
  logic [vp_pkg::DMEM_DW-1:0]               rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wvalid, wdata,
    input  cmd_ready, wready, rvalid, rlast, rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wvalid, wdata,
    output cmd_ready, wready, rvalid, rlast, rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select; on a tie the port other than last_grant wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       win
);

  always_comb begin
    win   = 1'b0;
    grant = '0;
    if (req == 2'b11) begin
      win = ~last_grant;
    end else begin
      win = req[1];
    end
    if (req != 2'b00) begin
      grant = win ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin command arbiter and burst sequencer driving the data memory,
// with a one-stage read-return pipe back to the granted requester.
module dmem_arbiter
  import vp_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LENW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_arbiter_if.slave       bus,
  output logic                mem_file_enable,
  output logic                mem_write_flag,
  output logic [DMEM_AW-1:0]  mem_dir,
  output logic [DMEM_DW-1:0]  mem_data_in,
  input  logic [DMEM_DW-1:0]  mem_data_out
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t          state;
  logic [GW-1:0]       gnt;
  logic                last_grant;
  logic [DMEM_AW-1:0]  addr;
  logic [LENW-1:0]     beats_left;
  logic [NREQ-1:0]     rv;
  logic                rlast_q;

  logic [1:0]          grant;
  logic                win;
  logic [NREQ-1:0]     gnt_onehot;
  logic                issue_rd;
  logic                issue_wr;
  logic                issue;
  logic                last_beat;

  rr_arbiter2 u_rr (
    .req        (bus.cmd_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .win        (win)
  );

  always_comb begin
    gnt_onehot = NREQ'(1) << gnt;
    issue_rd   = (state == RD);
    issue_wr   = (state == WR) && bus.wvalid[gnt];
    issue      = issue_rd || issue_wr;
    last_beat  = (beats_left == '0);
  end

  // Memory-side signals are decoded from registered state and forced to zero
  // outside an issued beat, so an async reset drops them immediately.
  always_comb begin
    mem_file_enable = issue;
    mem_write_flag  = issue_wr;
    mem_dir         = issue ? addr : '0;
    mem_data_in     = issue_wr ? bus.wdata[gnt] : '0;
  end

  assign bus.cmd_ready = (state == IDLE) ? grant : '0;
  assign bus.wready    = (state == WR) ? gnt_onehot : '0;
  assign bus.rvalid    = rv;
  assign bus.rlast     = rlast_q;
  assign bus.rdata     = (|rv) ? mem_data_out : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      last_grant <= 1'b1;
      addr       <= '0;
      beats_left <= '0;
      rv         <= '0;
      rlast_q    <= 1'b0;
    end else begin
      rv      <= issue_rd ? gnt_onehot : '0;
      rlast_q <= issue_rd && last_beat;
      unique case (state)
        IDLE: begin
          if (|grant) begin
            gnt        <= GW'(win);
            last_grant <= win;
            addr       <= bus.cmd_addr[win];
            beats_left <= bus.cmd_len[win];
            state      <= bus.cmd_write[win] ? WR : RD;
          end
        end
        RD: begin
          addr       <= addr + DMEM_AW'(1);
          beats_left <= beats_left - LENW'(1);
          if (last_beat) state <= IDLE;
        end
        WR: begin
          if (bus.wvalid[gnt]) begin
            addr       <= addr + DMEM_AW'(1);
            beats_left <= beats_left - LENW'(1);
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural dmem model.
module tb_dmem_arbiter;
  import vp_pkg::*;

  typedef struct {
    logic         wr;
    logic [14:0]  dir;
    logic [63:0]  data;
  } iss_t;

  typedef struct {
    int           port;
    logic         last;
    logic [63:0]  data;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NREQ(2), .LENW(3)) bus ();

  logic        mem_file_enable;
  logic        mem_write_flag;
  logic [14:0] mem_dir;
  logic [63:0] mem_data_in;
  logic [63:0] mem_data_out;

  dmem_arbiter #(.NREQ(2), .LENW(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .mem_file_enable (mem_file_enable),
    .mem_write_flag  (mem_write_flag),
    .mem_dir         (mem_dir),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out)
  );

  logic [63:0] mem [0:32767];
  logic        bd_init = 1'b0;
  logic        bd_en = 1'b0;
  logic [14:0] bd_addr = '0;
  logic [63:0] bd_data = '0;

  function automatic logic [63:0] pat(input logic [14:0] a);
    return 64'hC0DE_0000_0000_0000 | {49'd0, a};
  endfunction

  always @(posedge clk) begin
    if (bd_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= pat(15'(i));
    end else if (bd_en) begin
      mem[bd_addr] <= bd_data;
    end
    if (mem_file_enable) begin
      if (mem_write_flag) mem[mem_dir] <= mem_data_in;
      else                mem_data_out <= mem[mem_dir];
    end
  end

  int   exp_gnt [$];
  iss_t exp_iss [$];
  rd_t  exp_rd  [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input int port, input logic wr, input logic [14:0] a, input logic [2:0] len);
    logic got;
    got = 1'b0;
    exp_gnt.push_back(port);
    bus.cmd_write[port] = wr;
    bus.cmd_addr[port]  = a;
    bus.cmd_len[port]   = len;
    bus.cmd_valid[port] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.cmd_ready[port]) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid[port] = 1'b0;
    chk("cmd_accept", got, 1);
  endtask

  task automatic read_burst(input int port, input logic [14:0] a, input logic [2:0] len,
                            input logic [63:0] base, input logic use_pat);
    for (int i = 0; i <= int'(len); i++) begin
      iss_t e;
      rd_t  r;
      e.wr = 1'b0; e.dir = a + 15'(i); e.data = '0;
      r.port = port; r.last = (i == int'(len));
      r.data = use_pat ? pat(a + 15'(i)) : base + 64'(i);
      exp_iss.push_back(e);
      exp_rd.push_back(r);
    end
    issue_cmd(port, 1'b0, a, len);
  endtask

  task automatic write_burst(input int port, input logic [14:0] a, input logic [2:0] len,
                             input logic [63:0] base, input logic gap);
    for (int i = 0; i <= int'(len); i++) begin
      iss_t e;
      e.wr = 1'b1; e.dir = a + 15'(i); e.data = base + 64'(i);
      exp_iss.push_back(e);
    end
    issue_cmd(port, 1'b1, a, len);
    for (int i = 0; i <= int'(len); i++) begin
      bus.wvalid[port] = 1'b1;
      bus.wdata[port]  = base + 64'(i);
      @(negedge clk);
      chk("wready_owner_only", bus.wready, 2'b01 << port);
      @(posedge clk);
      #1;
      bus.wvalid[port] = 1'b0;
      if (gap && i < int'(len)) begin
        @(negedge clk);
        chk("gap_no_enable", mem_file_enable, 0);
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int total;
    logic [1:0] r;

    bus.cmd_valid = '0;
    bus.cmd_write = '0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wvalid    = '0;
    bus.wdata     = '0;

    fork
      forever begin
        @(negedge clk);
        if (|bus.cmd_ready) begin
          if (exp_gnt.size() == 0) chk("grant_unexpected", bus.cmd_ready, 0);
          else chk("grant", bus.cmd_ready, 2'b01 << exp_gnt.pop_front());
        end
        if (mem_file_enable) begin
          if (exp_iss.size() == 0) begin
            chk("issue_unexpected", mem_file_enable, 0);
          end else begin
            iss_t e;
            e = exp_iss.pop_front();
            chk("issue_kind", mem_write_flag, e.wr);
            chk("issue_dir", mem_dir, e.dir);
            if (e.wr) chk("issue_wdata", mem_data_in, e.data);
          end
        end else begin
          chk("idle_mem_outputs", {mem_write_flag, mem_dir, mem_data_in}, 0);
        end
        if (|bus.rvalid) begin
          if (exp_rd.size() == 0) begin
            chk("rvalid_unexpected", bus.rvalid, 0);
          end else begin
            rd_t x;
            x = exp_rd.pop_front();
            chk("rvalid_port", bus.rvalid, 2'b01 << x.port);
            chk("rlast", bus.rlast, x.last);
            chk("rdata", bus.rdata, x.data);
          end
        end else begin
          chk("idle_read_outputs", {bus.rlast, bus.rdata}, 0);
        end
      end
    join_none

    // Reset state and backdoor setup
    bd_init = 1'b1;
    @(posedge clk);
    #1;
    bd_init = 1'b0;
    @(negedge clk);
    chk("reset_bus_outputs", {bus.cmd_ready, bus.wready, bus.rvalid, bus.rlast, bus.rdata}, 0);
    chk("reset_mem_outputs", {mem_file_enable, mem_write_flag, mem_dir, mem_data_in}, 0);
    @(posedge clk);
    #1;
    bd_en = 1'b1; bd_addr = 15'h0010; bd_data = 64'hAAAA;
    @(posedge clk);
    #1;
    bd_en = 1'b0;
    rst_n = 1'b1;
    wait_cycles(2);

    // Single read with latency check
    read_burst(0, 15'h0010, 3'd0, 64'hAAAA, 1'b0);
    @(negedge clk);
    chk("single_issue_t1", {mem_file_enable, bus.rvalid}, 3'b100);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single_rvalid_t2", {bus.rvalid, bus.rlast}, 3'b011);
    wait_cycles(3);

    // Gapped write then read-back on port 1
    write_burst(1, 15'h0100, 3'd3, 64'd1, 1'b1);
    wait_cycles(2);
    read_burst(1, 15'h0100, 3'd3, 64'd1, 1'b0);
    wait_cycles(7);
    for (int i = 0; i < 4; i++) chk("mem_after_write", mem[15'h0100 + 15'(i)], 64'(i + 1));

    // Contention: both ports held, four accepts
    for (int i = 0; i < 4; i++) begin
      iss_t e;
      rd_t  x;
      int   p;
      p = i % 2;
      exp_gnt.push_back(p);
      e.wr = 1'b0; e.dir = (p == 0) ? 15'h0020 : 15'h0030; e.data = '0;
      x.port = p; x.last = 1'b1; x.data = pat(e.dir);
      exp_iss.push_back(e);
      exp_rd.push_back(x);
    end
    bus.cmd_write = '0;
    bus.cmd_addr[0] = 15'h0020;
    bus.cmd_addr[1] = 15'h0030;
    bus.cmd_len = '0;
    bus.cmd_valid = 2'b11;
    total = 0;
    for (int k = 0; k < 100 && total < 4; k++) begin
      @(negedge clk);
      r = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (|r) total++;
    end
    bus.cmd_valid = '0;
    chk("contention_accepts", total, 4);
    wait_cycles(4);

    // Address wrap
    read_burst(0, 15'h7FFE, 3'd3, 64'd0, 1'b1);
    wait_cycles(7);

    // Reset during beat 2 of a len-7 write on port 0
    for (int i = 0; i < 2; i++) begin
      iss_t e;
      e.wr = 1'b1; e.dir = 15'h0200 + 15'(i); e.data = 64'h11 * 64'(i + 1);
      exp_iss.push_back(e);
    end
    issue_cmd(0, 1'b1, 15'h0200, 3'd7);
    bus.wvalid[0] = 1'b1;
    bus.wdata[0]  = 64'h11;
    @(posedge clk);
    #1;
    bus.wdata[0] = 64'h22;
    @(posedge clk);
    #1;
    bus.wdata[0] = 64'h33;
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_bus_outputs", {bus.cmd_ready, bus.wready, bus.rvalid, bus.rlast, bus.rdata}, 0);
    chk("midreset_mem_outputs", {mem_file_enable, mem_write_flag, mem_dir, mem_data_in}, 0);
    bus.wvalid = '0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
    chk("mem_beat0", mem[15'h0200], 64'h11);
    chk("mem_beat1", mem[15'h0201], 64'h22);
    for (int i = 2; i < 8; i++) chk("mem_untouched", mem[15'h0200 + 15'(i)], pat(15'h0200 + 15'(i)));

    // First tie after reset goes to port 0
    begin
      iss_t e;
      rd_t  x;
      exp_gnt.push_back(0);
      e.wr = 1'b0; e.dir = 15'h0040; e.data = '0;
      x.port = 0; x.last = 1'b1; x.data = pat(15'h0040);
      exp_iss.push_back(e);
      exp_rd.push_back(x);
    end
    bus.cmd_write = '0;
    bus.cmd_addr[0] = 15'h0040;
    bus.cmd_addr[1] = 15'h0050;
    bus.cmd_len = '0;
    bus.cmd_valid = 2'b11;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.cmd_valid = '0;
    wait_cycles(5);

    chk("grants_drained", exp_gnt.size(), 0);
    chk("issues_drained", exp_iss.size(), 0);
    chk("reads_drained", exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
